// File: rtl/dual_prio_enc.sv
// Registered 12-request dual priority encoder: reports the two highest-priority
// request codes (bit 0 highest, 1-based, 0 = none). Optional input stage: DUAL_PRIO_ENC_INPUT_REG_EN.
module dual_prio_enc (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] req_d,
   output logic [3:0]  first,
   output logic [3:0]  second
);

   // Lowest set bit wins; scanning downward lets the lowest index overwrite.
   function automatic logic [3:0] enc12(input logic [11:0] vec);
      logic [3:0] code;
      code = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (vec[i]) begin
            code = 4'(i + 1);
         end
      end
      return code;
   endfunction

   logic [11:0] sample;
   logic [11:0] remainder;
   logic [3:0]  first_next;
   logic [3:0]  second_next;

`ifdef DUAL_PRIO_ENC_INPUT_REG_EN
   logic [11:0] req_q;

   // Input stage register for late-arriving requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= 12'd0;
      end else begin
         req_q <= req_d;
      end
   end

   assign sample = req_q;
`else
   assign sample = req_d;
`endif

   // Encode the winner, then clear the lowest set bit and encode the runner-up.
   always_comb begin
      first_next  = 4'd0;
      second_next = 4'd0;
      remainder   = 12'd0;
      if (sample != 12'd0) begin
         first_next  = enc12(sample);
         remainder   = sample & (sample - 12'd1);
         second_next = enc12(remainder);
      end else begin
         first_next  = 4'd0;
         second_next = 4'd0;
      end
   end

   // Output registers; both codes always come from the same sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first  <= 4'd0;
         second <= 4'd0;
      end else begin
         first  <= first_next;
         second <= second_next;
      end
   end

endmodule

// File: tb/tb_dual_prio_enc.sv
// Self-checking bench for dual_prio_enc: directed vector table, reset/latency/
// back-to-back sequences, and an exhaustive sweep against a counting model.
module tb_dual_prio_enc;

`ifdef DUAL_PRIO_ENC_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic [11:0] req_d;
   logic [3:0]  first;
   logic [3:0]  second;

   int tests;
   int fails;

   typedef struct {
      string       name;
      logic [11:0] req;
      logic [3:0]  f;
      logic [3:0]  s;
   } vec_t;

   vec_t vecs[8];

   dual_prio_enc dut (
      .clk    (clk),
      .rst    (rst),
      .req_d  (req_d),
      .first  (first),
      .second (second)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] ef, input logic [3:0] es);
      tests++;
      if (first !== ef || second !== es) begin
         fails++;
         $display("FAIL %s: got first=%0d second=%0d, expected first=%0d second=%0d",
                  name, first, second, ef, es);
      end
   endtask

   // Drive at the falling edge, then wait for the result to reach the outputs.
   task automatic step(input logic [11:0] v);
      @(negedge clk);
      req_d = v;
      repeat (LAT) @(posedge clk);
      #1;
   endtask

   // Independent reference: count set bits from the top-priority end.
   task automatic model(input logic [11:0] v, output logic [3:0] f, output logic [3:0] s);
      int n;
      n = 0;
      f = 4'd0;
      s = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (v[i]) begin
            if (n == 0) f = 4'(i + 1);
            else if (n == 1) s = 4'(i + 1);
            n++;
         end
      end
   endtask

   initial begin
      logic [3:0]  mf;
      logic [3:0]  ms;
      logic [11:0] seq [3];
      logic [3:0]  seq_f [3];
      logic [3:0]  seq_s [3];
      int          k;

      tests = 0;
      fails = 0;
      vecs[0] = '{"empty",  12'h000, 4'd0,  4'd0};
      vecs[1] = '{"bit0",   12'h001, 4'd1,  4'd0};
      vecs[2] = '{"bit11",  12'h800, 4'd12, 4'd0};
      vecs[3] = '{"pair01", 12'h003, 4'd1,  4'd2};
      vecs[4] = '{"top2",   12'hC00, 4'd11, 4'd12};
      vecs[5] = '{"spread", 12'h081, 4'd1,  4'd8};
      vecs[6] = '{"all",    12'hFFF, 4'd1,  4'd2};
      vecs[7] = '{"mid",    12'h0A0, 4'd6,  4'd8};

      rst   = 1'b1;
      req_d = 12'h003;
      #3;
      check("reset_state", 4'd0, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step(vecs[i].req);
         check(vecs[i].name, vecs[i].f, vecs[i].s);
      end

      // Asynchronous reset in the middle of a cycle with live requests.
      step(12'h003);
      check("pre_reset", 4'd1, 4'd2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("reset_async", 4'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", 4'd0, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release_edge1", (LAT == 1) ? 4'd1 : 4'd0, (LAT == 1) ? 4'd2 : 4'd0);
      @(posedge clk);
      #1;
      check("reset_release_edge2", 4'd1, 4'd2);

      // Latency: prior value held until exactly LAT edges after the change.
      step(12'h000);
      check("lat_base", 4'd0, 4'd0);
      @(negedge clk);
      req_d = 12'h024;
      @(posedge clk);
      #1;
      check("lat_edge1", (LAT == 1) ? 4'd3 : 4'd0, (LAT == 1) ? 4'd6 : 4'd0);
      @(posedge clk);
      #1;
      check("lat_edge2", 4'd3, 4'd6);

      // Back-to-back changes every cycle, no bubbles.
      seq[0] = 12'h001; seq_f[0] = 4'd1; seq_s[0] = 4'd0;
      seq[1] = 12'h006; seq_f[1] = 4'd2; seq_s[1] = 4'd3;
      seq[2] = 12'h000; seq_f[2] = 4'd0; seq_s[2] = 4'd0;
      step(12'hFFF);
      for (int c = 0; c < 3 + LAT; c++) begin
         @(negedge clk);
         req_d = (c < 3) ? seq[c] : 12'h000;
         @(posedge clk);
         #1;
         k = c - (LAT - 1);
         if (k >= 0 && k < 3) begin
            check($sformatf("b2b_%0d", k), seq_f[k], seq_s[k]);
         end
      end

      // Exhaustive sweep against the model plus ordering properties.
      for (int v = 0; v < 4096; v++) begin
         step(12'(v));
         model(12'(v), mf, ms);
         check($sformatf("exh_%03h", v), mf, ms);
         tests++;
         if ((second != 4'd0 && second <= first) || (first == 4'd0 && second != 4'd0)
             || first > 4'd12 || second > 4'd12) begin
            fails++;
            $display("FAIL order_%03h: got first=%0d second=%0d, expected second>first or 0, codes<=12",
                     v, first, second);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
